// File: rtl/dflow_drv_pkg.sv
// Shared types and default widths for the ap_ctrl_hs initiator and its timestamp FIFO.
package dflow_drv_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int LAT_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } drv_state_t;

    typedef logic [LAT_W_DEF-1:0] stamp_t;

endpackage

// File: rtl/dflow_stamp_fifo.sv
// Register FIFO of start timestamps; a push into an empty FIFO with a
// simultaneous pop passes the pushed stamp straight through to pop_data.
module dflow_stamp_fifo
    import dflow_drv_pkg::*;
#(
    parameter int W     = LAT_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         empty,
    output logic         full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          bypass;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (PW + 1)'(DEPTH));
    assign bypass   = empty & push & pop;
    assign do_push  = push & ~full & ~bypass;
    assign do_pop   = pop & ~empty;
    assign pop_data = empty ? push_data : mem_reg[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/ap_ctrl_hs_driver.sv
// Initiator for the ap_ctrl_hs/ap_ctrl_chain block handshake with latency reporting.
// Optional watchdog enabled by defining DFLOW_DRV_TIMEOUT_EN.
module ap_ctrl_hs_driver
    import dflow_drv_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int LAT_W       = LAT_W_DEF,
    parameter int MAX_OUT     = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_num_txn,
    input  logic [7:0]       cfg_cont_gap,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             busy,
    output logic             finish,
    output logic [CNT_W-1:0] txn_issued,
    output logic [CNT_W-1:0] txn_done,
    output logic             lat_valid,
    output logic [LAT_W-1:0] lat_value,
    output logic             proto_err,
    output logic             timeout_err
);
    drv_state_t       state_reg, state_next;
    logic [CNT_W-1:0] num_reg, num_next;
    logic [7:0]       gap_reg, gap_next;
    logic [CNT_W-1:0] issued_reg, issued_next;
    logic [CNT_W-1:0] done_reg, done_next;
    logic             start_reg, start_next;
    logic             cont_reg, cont_next;
    logic [7:0]       cont_cnt_reg, cont_cnt_next;
    logic             lat_valid_reg, lat_valid_next;
    logic [LAT_W-1:0] lat_value_reg, lat_value_next;
    logic             proto_reg, proto_next;
    logic [LAT_W-1:0] cyc_reg;

    logic             active;
    logic             start_acc;
    logic             done_acc;
    logic             fifo_push;
    logic             fifo_pop;
    logic [LAT_W-1:0] fifo_data;
    logic             fifo_empty;
    logic             fifo_full;

`ifdef DFLOW_DRV_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wdog_reg, wdog_next;
    logic            timeout_reg, timeout_next;
`endif

    assign active    = (state_reg == ISSUE) || (state_reg == DRAIN);
    assign start_acc = start_reg & ap_ready;
    assign done_acc  = ap_done & cont_reg;
    assign fifo_push = start_acc;
    // A done is legitimate if something is outstanding or is being started this very cycle.
    assign fifo_pop  = active & done_acc & (~fifo_empty | start_acc);

    dflow_stamp_fifo #(
        .W     (LAT_W),
        .DEPTH (MAX_OUT)
    ) u_stamp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (cyc_reg),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        state_next     = state_reg;
        num_next       = num_reg;
        gap_next       = gap_reg;
        issued_next    = issued_reg;
        done_next      = done_reg;
        start_next     = 1'b0;
        cont_next      = cont_reg;
        cont_cnt_next  = cont_cnt_reg;
        lat_valid_next = 1'b0;
        lat_value_next = lat_value_reg;
        proto_next     = proto_reg;

        if (!cont_reg) begin
            if (cont_cnt_reg == 8'd0) begin
                cont_next = 1'b1;
            end else begin
                cont_cnt_next = cont_cnt_reg - 8'd1;
            end
        end

        case (state_reg)
            IDLE, DONE: begin
                if (cfg_start) begin
                    num_next    = cfg_num_txn;
                    gap_next    = cfg_cont_gap;
                    issued_next = '0;
                    done_next   = '0;
                    proto_next  = 1'b0;
                    state_next  = (cfg_num_txn == '0) ? DONE : ISSUE;
                end else if (ap_done) begin
                    proto_next = 1'b1;
                end
            end
            ISSUE, DRAIN: begin
                if (start_acc) begin
                    issued_next = issued_reg + CNT_W'(1);
                end
                if (done_acc) begin
                    if (fifo_pop) begin
                        done_next      = done_reg + CNT_W'(1);
                        lat_valid_next = 1'b1;
                        lat_value_next = cyc_reg - fifo_data;
                        if (gap_reg != 8'd0) begin
                            cont_next     = 1'b0;
                            cont_cnt_next = gap_reg - 8'd1;
                        end
                    end else begin
                        proto_next = 1'b1;
                    end
                end
                if (state_reg == ISSUE) begin
                    if (issued_next == num_reg) begin
                        state_next = DRAIN;
                    end else if (start_reg && !ap_ready) begin
                        // a raised ap_start may not be withdrawn before ap_ready
                        start_next = 1'b1;
                    end else begin
                        start_next = ((issued_next - done_next) < CNT_W'(MAX_OUT))
                                     && !(fifo_full && !fifo_pop);
                    end
                end else if (done_next == num_reg) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase

`ifdef DFLOW_DRV_TIMEOUT_EN
        wdog_next    = '0;
        timeout_next = timeout_reg;
        if (active && !(start_acc || done_acc)) begin
            wdog_next = wdog_reg + WD_W'(1);
            if (wdog_next == WD_W'(TIMEOUT_CYC)) begin
                timeout_next = 1'b1;
                start_next   = 1'b0;
                state_next   = DONE;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            num_reg       <= '0;
            gap_reg       <= '0;
            issued_reg    <= '0;
            done_reg      <= '0;
            start_reg     <= 1'b0;
            cont_reg      <= 1'b1;
            cont_cnt_reg  <= '0;
            lat_valid_reg <= 1'b0;
            lat_value_reg <= '0;
            proto_reg     <= 1'b0;
            cyc_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            num_reg       <= num_next;
            gap_reg       <= gap_next;
            issued_reg    <= issued_next;
            done_reg      <= done_next;
            start_reg     <= start_next;
            cont_reg      <= cont_next;
            cont_cnt_reg  <= cont_cnt_next;
            lat_valid_reg <= lat_valid_next;
            lat_value_reg <= lat_value_next;
            proto_reg     <= proto_next;
            cyc_reg       <= cyc_reg + LAT_W'(1);
        end
    end

`ifdef DFLOW_DRV_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            wdog_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            wdog_reg    <= wdog_next;
            timeout_reg <= timeout_next;
        end
    end
    assign timeout_err = timeout_reg;
`else
    assign timeout_err = 1'b0;
`endif

    assign ap_start    = start_reg;
    assign ap_continue = cont_reg;
    assign busy        = active;
    assign finish      = (state_reg == DONE);
    assign txn_issued  = issued_reg;
    assign txn_done    = done_reg;
    assign lat_valid   = lat_valid_reg;
    assign lat_value   = lat_value_reg;
    assign proto_err   = proto_reg;

endmodule

// File: tb/tb_ap_ctrl_hs_driver.sv
// Bench for ap_ctrl_hs_driver: a reactive DUT-side responder plus a queue-based
// latency/backpressure model; LAT_W is narrowed to 8 so the cycle counter wraps.
module tb_ap_ctrl_hs_driver;
    localparam int TB_CNT_W = 16;
    localparam int TB_LAT_W = 8;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                cfg_start = 1'b0;
    logic [TB_CNT_W-1:0] cfg_num_txn = '0;
    logic [7:0]          cfg_cont_gap = '0;
    logic                ap_start;
    logic                ap_ready;
    logic                ap_done;
    logic                ap_continue;
    logic                busy;
    logic                finish;
    logic [TB_CNT_W-1:0] txn_issued;
    logic [TB_CNT_W-1:0] txn_done;
    logic                lat_valid;
    logic [TB_LAT_W-1:0] lat_value;
    logic                proto_err;
    logic                timeout_err;

    ap_ctrl_hs_driver #(
        .CNT_W   (TB_CNT_W),
        .LAT_W   (TB_LAT_W),
        .MAX_OUT (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_start    (cfg_start),
        .cfg_num_txn  (cfg_num_txn),
        .cfg_cont_gap (cfg_cont_gap),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .busy         (busy),
        .finish       (finish),
        .txn_issued   (txn_issued),
        .txn_done     (txn_done),
        .lat_valid    (lat_valid),
        .lat_value    (lat_value),
        .proto_err    (proto_err),
        .timeout_err  (timeout_err)
    );

    always #5 clock = ~clock;

    int n = 0;
    always @(posedge clock) n <= n + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // responder knobs and model state
    bit resp_en = 1'b1;
    bit rdy_rand = 1'b0;
    bit dl_rand = 1'b0;
    bit hold_done = 1'b0;
    int done_lat = 5;
    int gap_cfg = 0;
    int start_q[$];
    int due_q[$];
    logic [TB_LAT_W-1:0] exp_lat[$];
    int n_lat, n_spur, start_viol, max_outst, cont_low, last_acc, start_seen;
    int last_lat;
    bit have_acc, prev_start, prev_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // DUT-side responder and reference model, acting on falling edges
    initial begin
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                start_q.delete();
                due_q.delete();
                exp_lat.delete();
                n_lat = 0; n_spur = 0; max_outst = 0; cont_low = 0;
                have_acc = 1'b0; prev_start = 1'b0; prev_acc = 1'b0;
                start_seen = 0; last_lat = -1;
                ap_ready = 1'b0;
                ap_done  = 1'b0;
            end else begin
                if (lat_valid) begin
                    last_lat = int'(lat_value);
                    if (exp_lat.size() == 0) n_spur++;
                    else begin
                        n_lat++;
                        check("lat_value", 32'(lat_value), 32'(exp_lat.pop_front()));
                    end
                end
                check("ap_continue", 32'(ap_continue),
                      (have_acc && n > last_acc && n <= last_acc + gap_cfg) ? 0 : 1);
                if (!ap_continue) cont_low++;
                if (ap_start) start_seen++;
                if (prev_start && !prev_acc && !ap_start) start_viol++;
                if (resp_en) begin
                    ap_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (ap_start && ap_ready) begin
                        start_q.push_back(n);
                        due_q.push_back(n + (dl_rand ? int'($urandom_range(1, 40)) : done_lat));
                    end
                    if (!hold_done && due_q.size() > 0 && due_q[0] <= n) begin
                        ap_done = 1'b1;
                        if (ap_continue) begin
                            void'(due_q.pop_front());
                            exp_lat.push_back(TB_LAT_W'(n - start_q.pop_front()));
                            have_acc = 1'b1;
                            last_acc = n;
                        end
                    end else begin
                        ap_done = 1'b0;
                    end
                    if (start_q.size() > max_outst) max_outst = start_q.size();
                end
                prev_start = ap_start;
                prev_acc   = ap_start && ap_ready;
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
    endtask

    task automatic start_run(input int num, input int gap);
        cfg_num_txn  = TB_CNT_W'(num);
        cfg_cont_gap = 8'(gap);
        gap_cfg      = gap;
        cfg_start    = 1'b1;
        step(1);
        cfg_start    = 1'b0;
    endtask

    task automatic wait_finish(input int budget);
        int k = 0;
        while (!finish && k < budget) begin
            step(1);
            k++;
        end
        check("finish", 32'(finish), 1);
        step(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int k;
        step(1);

        // reset state
        do_reset();
        check("rst_ap_start", 32'(ap_start), 0);
        check("rst_ap_continue", 32'(ap_continue), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_finish", 32'(finish), 0);
        check("rst_txn_issued", 32'(txn_issued), 0);
        check("rst_txn_done", 32'(txn_done), 0);
        check("rst_lat_valid", 32'(lat_valid), 0);
        check("rst_lat_value", 32'(lat_value), 0);
        check("rst_proto_err", 32'(proto_err), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);

        // three transactions, ready at once, done five cycles later
        rdy_rand = 1'b0; dl_rand = 1'b0; hold_done = 1'b0; done_lat = 5;
        start_run(3, 0);
        check("t1_busy", 32'(busy), 1);
        wait_finish(200);
        check("t1_issued", 32'(txn_issued), 3);
        check("t1_done", 32'(txn_done), 3);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_n_lat", 32'(n_lat), 3);
        check("t1_last_lat", 32'(last_lat), 5);

        // zero-length run
        do_reset();
        start_run(0, 0);
        check("t2_finish", 32'(finish), 1);
        check("t2_busy", 32'(busy), 0);
        step(5);
        check("t2_start_seen", 32'(start_seen), 0);
        check("t2_issued", 32'(txn_issued), 0);

        // outstanding limit with dones withheld
        do_reset();
        hold_done = 1'b1; done_lat = 2;
        start_run(8, 0);
        k = 0;
        while (txn_issued != 4 && k < 50) begin step(1); k++; end
        step(10);
        check("t3_issued_capped", 32'(txn_issued), 4);
        check("t3_start_low", 32'(ap_start), 0);
        check("t3_model_outst", 32'(start_q.size()), 4);
        hold_done = 1'b0;
        wait_finish(300);
        check("t3_issued", 32'(txn_issued), 8);
        check("t3_done", 32'(txn_done), 8);
        check("t3_max_outst", 32'(max_outst), 4);

        // continue backpressure gap of three
        do_reset();
        rdy_rand = 1'b1; done_lat = 1;
        start_run(4, 3);
        wait_finish(500);
        step(4);
        check("t4_cont_low", 32'(cont_low), 12);
        check("t4_done", 32'(txn_done), 4);

        // done together with ready on an empty FIFO
        do_reset();
        rdy_rand = 1'b0; done_lat = 0;
        start_run(3, 0);
        wait_finish(200);
        check("t5_last_lat", 32'(last_lat), 0);
        check("t5_n_lat", 32'(n_lat), 3);
        check("t5_proto", 32'(proto_err), 0);
        check("t5_done", 32'(txn_done), 3);

        // randomized run across cycle-counter wrap
        do_reset();
        step(250);
        rdy_rand = 1'b1; dl_rand = 1'b1;
        start_run(40, int'($urandom_range(0, 2)));
        wait_finish(5000);
        check("t6_done", 32'(txn_done), 40);
        check("t6_n_lat", 32'(n_lat), 40);
        check("t6_lat_left", 32'(exp_lat.size()), 0);
        check("t6_outst_ok", 32'(max_outst <= 4), 1);
        check("t6_proto", 32'(proto_err), 0);

        // reset in DRAIN, then spurious done in IDLE
        do_reset();
        rdy_rand = 1'b0; dl_rand = 1'b0; hold_done = 1'b1; done_lat = 2;
        start_run(2, 0);
        k = 0;
        while (!(busy && txn_issued == 2) && k < 50) begin step(1); k++; end
        step(2);
        check("t7_in_drain", 32'(busy), 1);
        reset = 1'b1;
        step(1);
        check("t7_rst_start", 32'(ap_start), 0);
        check("t7_rst_busy", 32'(busy), 0);
        check("t7_rst_finish", 32'(finish), 0);
        check("t7_rst_issued", 32'(txn_issued), 0);
        check("t7_rst_done", 32'(txn_done), 0);
        check("t7_rst_cont", 32'(ap_continue), 1);
        reset = 1'b0;
        hold_done = 1'b0;
        resp_en = 1'b0;
        step(2);
        ap_done = 1'b1;
        step(1);
        ap_done = 1'b0;
        check("t7_proto_set", 32'(proto_err), 1);
        step(3);
        check("t7_proto_sticky", 32'(proto_err), 1);
        resp_en = 1'b1;
        start_run(0, 0);
        check("t7_proto_clr", 32'(proto_err), 0);
        check("t7_finish", 32'(finish), 1);

        check("start_held", 32'(start_viol), 0);
        check("lat_spurious", 32'(n_spur), 0);
        check("timeout_err", 32'(timeout_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
